// File: rtl/vid_timing_gen_if.sv
// Line-fetch handshake between the raster timing generator and the
// downstream prefetch stage. The generator raises line_req with the line
// index and holds it until the consumer answers with line_ack.
interface vid_timing_gen_if;
    logic        line_req;
    logic [11:0] line_num;
    logic        line_ack;

    // Timing generator side: issues requests, receives acknowledges
    modport master (
        output line_req,
        output line_num,
        input  line_ack
    );

    // Prefetch stage side: receives requests, returns acknowledges
    modport slave (
        input  line_req,
        input  line_num,
        output line_ack
    );
endinterface

// File: rtl/vid_timing_gen.sv
// Raster timing generator for the video output stage.
// Produces sync/blank/data-enable decodes and pixel coordinates, advancing
// one pixel per clk cycle with enable high. One line ahead of display it
// requests a prefetch of the next visible line over the line_bus handshake,
// and flags a sticky underrun if a previous request was never accepted.
module vid_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    vid_timing_gen_if.master   line_bus,
    input  logic               clr_underrun,
    output logic [11:0]        hcount,
    output logic [11:0]        vcount,
    output logic               hsync,
    output logic               hblank,
    output logic               vsync,
    output logic               vblank,
    output logic               de,
    output logic               frame_start,
    output logic               underrun
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST       = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST       = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT        = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT        = 12'(V_ACTIVE);
    localparam logic [11:0] H_SYNC_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYNC_END   = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [11:0] V_SYNC_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SYNC_END   = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic        prime;
    logic        line_req_q;
    logic [11:0] line_num_q;

    logic        advance;
    logic        h_wrap;
    logic        v_wrap;
    logic [11:0] h_next;
    logic [11:0] v_next;
    logic [11:0] next_line;
    logic        req_point;
    logic        set_underrun;

    assign line_bus.line_req = line_req_q;
    assign line_bus.line_num = line_num_q;

    // Next raster position, the line that follows the current one, and the
    // request point; the prime cycle is spent on the line-0 prefetch, so the
    // raster only starts moving on the edge after it.
    always_comb begin
        advance   = enable && !prime;
        h_wrap    = (hcount == H_LAST);
        v_wrap    = (vcount == V_LAST);
        h_next    = hcount;
        v_next    = vcount;
        if (advance) begin
            if (h_wrap) begin
                h_next = '0;
                v_next = v_wrap ? 12'd0 : vcount + 12'd1;
            end else begin
                h_next = hcount + 12'd1;
            end
        end
        next_line    = v_wrap ? 12'd0 : vcount + 12'd1;
        req_point    = advance && (h_next == H_ACT) && (next_line < V_ACT);
        set_underrun = req_point && line_req_q && !line_bus.line_ack;
    end

    // Pixel and line counters; reset parks them on the last position so the
    // first advance lands on (0,0).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcount <= H_LAST;
            vcount <= V_LAST;
        end else begin
            hcount <= h_next;
            vcount <= v_next;
        end
    end

    // Decodes registered from the next position so they line up with the
    // counters shown in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hblank      <= 1'b1;
            vblank      <= 1'b1;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            de          <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hblank      <= (h_next >= H_ACT);
            vblank      <= (v_next >= V_ACT);
            hsync       <= (h_next >= H_SYNC_START) && (h_next <= H_SYNC_END);
            vsync       <= (v_next >= V_SYNC_START) && (v_next <= V_SYNC_END);
            de          <= (h_next < H_ACT) && (v_next < V_ACT);
            frame_start <= advance && (h_next == 12'd0) && (v_next == 12'd0);
        end
    end

    // Line request handshake: prime prefetch first, then a new request beats
    // a same-cycle acknowledge, otherwise an acknowledge retires the request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prime      <= 1'b1;
            line_req_q <= 1'b0;
            line_num_q <= '0;
        end else if (prime) begin
            prime      <= 1'b0;
            line_req_q <= 1'b1;
            line_num_q <= '0;
        end else if (req_point) begin
            line_req_q <= 1'b1;
            line_num_q <= next_line;
        end else if (line_req_q && line_bus.line_ack) begin
            line_req_q <= 1'b0;
        end
    end

    // Sticky underrun flag; a new underrun outranks a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            underrun <= 1'b0;
        end else if (set_underrun) begin
            underrun <= 1'b1;
        end else if (clr_underrun) begin
            underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vid_timing_gen.sv
// Testbench for vid_timing_gen on a small 16x8 raster. A positional model
// (raster index 0..127) predicts every output each cycle; directed scenarios
// add literal expectations for startup, handshake, underrun, enable
// throttling and asynchronous reset.
module tb_vid_timing_gen;

    localparam int H_ACT = 8;
    localparam int H_FP  = 2;
    localparam int H_SY  = 3;
    localparam int H_BP  = 3;
    localparam int V_ACT = 4;
    localparam int V_FP  = 1;
    localparam int V_SY  = 2;
    localparam int V_BP  = 1;
    localparam int HT    = H_ACT + H_FP + H_SY + H_BP;
    localparam int VT    = V_ACT + V_FP + V_SY + V_BP;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        clr_underrun = 1'b0;
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        hsync;
    logic        hblank;
    logic        vsync;
    logic        vblank;
    logic        de;
    logic        frame_start;
    logic        underrun;

    vid_timing_gen_if line_bus();

    vid_timing_gen #(
        .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
        .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .line_bus(line_bus),
        .clr_underrun(clr_underrun),
        .hcount(hcount),
        .vcount(vcount),
        .hsync(hsync),
        .hblank(hblank),
        .vsync(vsync),
        .vblank(vblank),
        .de(de),
        .frame_start(frame_start),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: raster index plus handshake bookkeeping
    int m_pos   = FRAME - 1;
    bit m_fs    = 1'b0;
    bit m_req   = 1'b0;
    int m_num   = 0;
    bit m_und   = 1'b0;
    bit m_prime = 1'b1;

    // Per-scenario statistics gathered at negedges
    bit rec = 1'b0;
    int n_samp, fs_first, fs_count, hs_count, vs_count, de_count, req_high, rise_count;
    int rise_v[8];
    int rise_h[8];
    int rise_n[8];
    bit prev_req = 1'b0;
    bit alt_phase = 1'b0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Model update on each edge, then compare DUT against it just after
    always @(posedge clk) begin
        int  h;
        int  v;
        int  nline;
        bit  adv;
        bit  set_u;
        if (!reset) begin
            m_pos = FRAME - 1; m_fs = 0; m_req = 0; m_num = 0; m_und = 0; m_prime = 1;
        end else begin
            adv = enable && !m_prime;
            if (adv) m_pos = (m_pos + 1) % FRAME;
            m_fs  = adv && (m_pos == 0);
            nline = ((m_pos / HT) == VT - 1) ? 0 : (m_pos / HT) + 1;
            set_u = 0;
            if (m_prime) begin
                m_req = 1; m_num = 0; m_prime = 0;
            end else if (adv && (m_pos % HT) == H_ACT && nline < V_ACT) begin
                set_u = m_req && !line_bus.line_ack;
                m_req = 1; m_num = nline;
            end else if (m_req && line_bus.line_ack) begin
                m_req = 0;
            end
            if (set_u) m_und = 1;
            else if (clr_underrun) m_und = 0;
        end
        #1;
        h = m_pos % HT;
        v = m_pos / HT;
        checkOutput("hcount", int'(hcount), h);
        checkOutput("vcount", int'(vcount), v);
        checkOutput("hblank", int'(hblank), int'(h >= H_ACT));
        checkOutput("hsync", int'(hsync), int'(h >= H_ACT + H_FP && h <= H_ACT + H_FP + H_SY - 1));
        checkOutput("vblank", int'(vblank), int'(v >= V_ACT));
        checkOutput("vsync", int'(vsync), int'(v >= V_ACT + V_FP && v <= V_ACT + V_FP + V_SY - 1));
        checkOutput("de", int'(de), int'(h < H_ACT && v < V_ACT));
        checkOutput("frame_start", int'(frame_start), int'(m_fs));
        checkOutput("line_req", int'(line_bus.line_req), int'(m_req));
        checkOutput("line_num", int'(line_bus.line_num), m_num);
        checkOutput("underrun", int'(underrun), int'(m_und));
    end

    // One cycle: observe outputs at the negedge, then drive the next inputs.
    // en_mode 0 = off, 1 = on, 2 = alternate; auto_ack acks each new request.
    task automatic applyStimulus(input int en_mode, input bit auto_ack, input bit clr);
        bit rise;
        @(negedge clk);
        rise = line_bus.line_req && !prev_req;
        prev_req = line_bus.line_req;
        if (rec) begin
            n_samp++;
            if (frame_start) begin
                fs_count++;
                if (fs_first < 0) fs_first = n_samp;
            end
            hs_count += int'(hsync);
            vs_count += int'(vsync);
            de_count += int'(de);
            req_high += int'(line_bus.line_req);
            if (rise) begin
                if (rise_count < 8) begin
                    rise_v[rise_count] = int'(vcount);
                    rise_h[rise_count] = int'(hcount);
                    rise_n[rise_count] = int'(line_bus.line_num);
                end
                rise_count++;
            end
        end
        case (en_mode)
            0: enable = 1'b0;
            1: enable = 1'b1;
            default: begin
                enable = alt_phase;
                alt_phase = !alt_phase;
            end
        endcase
        line_bus.line_ack = auto_ack && rise;
        clr_underrun = clr;
    endtask

    task automatic clearStats();
        n_samp = 0; fs_first = -1; fs_count = 0; hs_count = 0; vs_count = 0;
        de_count = 0; req_high = 0; rise_count = 0;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b0;
        enable = 1'b0;
        line_bus.line_ack = 1'b0;
        clr_underrun = 1'b0;
        repeat (2) @(negedge clk);
        prev_req = 1'b0;
    endtask

    task automatic releaseReset(input bit en0);
        reset = 1'b1;
        enable = en0;
        alt_phase = !en0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit found;
        int exp_v[4];
        int exp_n[4];
        exp_v[0] = 0; exp_v[1] = 1; exp_v[2] = 2; exp_v[3] = 7;
        exp_n[0] = 1; exp_n[1] = 2; exp_n[2] = 3; exp_n[3] = 0;
        line_bus.line_ack = 1'b0;
        #1 reset = 1'b0;

        // Startup with enable held high and every request acked next cycle
        $display("[TB] scenario: continuous enable with acks");
        doReset();
        releaseReset(1'b1);
        applyStimulus(1, 1'b1, 1'b0);
        checkOutput("prime_req", int'(line_bus.line_req), 1);
        checkOutput("prime_num", int'(line_bus.line_num), 0);
        checkOutput("prime_hcount", int'(hcount), 15);
        checkOutput("prime_vcount", int'(vcount), 7);
        checkOutput("prime_fs", int'(frame_start), 0);
        applyStimulus(1, 1'b1, 1'b0);
        checkOutput("first_hcount", int'(hcount), 0);
        checkOutput("first_vcount", int'(vcount), 0);
        checkOutput("first_fs", int'(frame_start), 1);
        checkOutput("first_de", int'(de), 1);
        checkOutput("first_req_acked", int'(line_bus.line_req), 0);
        clearStats();
        rec = 1'b1;
        repeat (128) applyStimulus(1, 1'b1, 1'b0);
        rec = 1'b0;
        checkOutput("frame_period", fs_first, 128);
        checkOutput("fs_count", fs_count, 1);
        checkOutput("hsync_cycles", hs_count, 24);
        checkOutput("vsync_cycles", vs_count, 32);
        checkOutput("de_cycles", de_count, 32);
        checkOutput("req_high_cycles", req_high, 4);
        checkOutput("req_rises", rise_count, 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("rise%0d_v", i), rise_v[i], exp_v[i]);
            checkOutput($sformatf("rise%0d_h", i), rise_h[i], 8);
            checkOutput($sformatf("rise%0d_num", i), rise_n[i], exp_n[i]);
        end
        checkOutput("ack_no_underrun", int'(underrun), 0);

        // No acknowledges: underrun at the first request point, then clear
        $display("[TB] scenario: no acks, underrun");
        doReset();
        releaseReset(1'b1);
        repeat (8) applyStimulus(1, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 1'b1);
        checkOutput("pre_rp_hcount", int'(hcount), 7);
        checkOutput("pre_rp_underrun", int'(underrun), 0);
        applyStimulus(1, 1'b0, 1'b0);
        checkOutput("rp_hcount", int'(hcount), 8);
        checkOutput("rp_underrun", int'(underrun), 1);
        checkOutput("rp_num1", int'(line_bus.line_num), 1);
        checkOutput("rp_req", int'(line_bus.line_req), 1);
        repeat (16) applyStimulus(1, 1'b0, 1'b0);
        checkOutput("rp_num2", int'(line_bus.line_num), 2);
        repeat (16) applyStimulus(1, 1'b0, 1'b0);
        checkOutput("rp_num3", int'(line_bus.line_num), 3);
        applyStimulus(1, 1'b0, 1'b1);
        applyStimulus(1, 1'b0, 1'b0);
        checkOutput("clr_underrun", int'(underrun), 0);
        checkOutput("clr_req_held", int'(line_bus.line_req), 1);

        // Alternating enable: half-rate raster, acks land on disabled cycles
        $display("[TB] scenario: alternating enable");
        doReset();
        releaseReset(1'b1);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(2, 1'b1, 1'b0);
            if (frame_start) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("alt_first_fs", int'(found), 1);
        clearStats();
        rec = 1'b1;
        repeat (256) applyStimulus(2, 1'b1, 1'b0);
        rec = 1'b0;
        checkOutput("alt_frame_period", fs_first, 256);
        checkOutput("alt_fs_count", fs_count, 1);
        checkOutput("alt_hsync_cycles", hs_count, 48);
        checkOutput("alt_req_high", req_high, 4);
        checkOutput("alt_req_rises", rise_count, 4);
        checkOutput("alt_underrun", int'(underrun), 0);

        // Asynchronous reset mid-frame with a request pending
        $display("[TB] scenario: async reset mid-frame");
        doReset();
        releaseReset(1'b1);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1, 1'b0, 1'b0);
            if (hcount == 12'd5 && vcount == 12'd2) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("reach_v2h5", int'(found), 1);
        checkOutput("pending_req", int'(line_bus.line_req), 1);
        #2 reset = 1'b0;
        #1;
        checkOutput("ar_hcount", int'(hcount), 15);
        checkOutput("ar_vcount", int'(vcount), 7);
        checkOutput("ar_hblank", int'(hblank), 1);
        checkOutput("ar_vblank", int'(vblank), 1);
        checkOutput("ar_de", int'(de), 0);
        checkOutput("ar_hsync", int'(hsync), 0);
        checkOutput("ar_vsync", int'(vsync), 0);
        checkOutput("ar_fs", int'(frame_start), 0);
        checkOutput("ar_req", int'(line_bus.line_req), 0);
        checkOutput("ar_num", int'(line_bus.line_num), 0);
        checkOutput("ar_underrun", int'(underrun), 0);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
